rom_dump_uart_tx: RTL and testbench
===================================

Name: rom_dump_uart_tx

Overview:
- Downstream stage of rom_reader. Serialises one ROM read result, the current address_line plus data_line, into a fixed 5-byte UART frame for the host PC.
- The frame is launched by a single-cycle send strobe, which top level raises once the read data is valid.
- Transmit only: 8N1, LSB first. Bit period is set by a clock divider.

Parameters:
DATA_WIDTH, 8, width of data_line; legal range 1..8, zero-extended to one byte
ADDRESS_WIDTH, 9, width of address_line; legal range 1..16, zero-extended to 16 bits
CLK_DIV, 434, clk cycles per UART bit (50 MHz / 115200); must be >= 2

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
send  input  1  one-cycle strobe; latch address/data and start a frame
address_line  input  ADDRESS_WIDTH  ROM address from rom_reader
data_line  input  DATA_WIDTH  ROM data from rom_reader
tx  output  1  UART serial line, idle high
busy  output  1  high while a frame is in progress
done  output  1  one-cycle pulse when the last stop bit of the frame completes
overrun  output  1  sticky flag: send arrived while busy

Behaviour:
- Reset (async, active-high), applied immediately:
  - tx=1, busy=0, done=0, overrun=0
  - FSM=IDLE; all counters and latches cleared.
- Frame byte order:
  - B0 = 8'hA5 (sync)
  - B1 = addr[15:8]
  - B2 = addr[7:0]
  - B3 = data (zero-extended)
  - B4 = (B1+B2+B3) mod 256 (checksum)
- Byte serialisation: start bit 0, then 8 data bits LSB first, then stop bit 1. Each bit lasts exactly CLK_DIV clk cycles.
- Frame length: 50*CLK_DIV cycles. There is no idle gap between bytes.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: tx=1.
    - On send=1 at rising edge N: latch address_line/data_line, compute the checksum, set byte index to 0, go to START.
    - busy=1 and tx=0 from edge N+1.
  - START: hold tx=0 for CLK_DIV cycles, then go to DATA with bit index 0.
  - DATA: drive tx=shift[0] for CLK_DIV cycles per bit. After bit 7, go to STOP.
  - STOP: hold tx=1 for CLK_DIV cycles, then:
    - if byte index < 4: increment the index, load the next byte, go to START;
    - if byte index = 4: go to IDLE. On that same edge busy falls to 0 and done=1 for exactly one cycle.
- Latency: send -> first start-bit edge is 1 cycle. send -> done is 50*CLK_DIV cycles.
- Input isolation: inputs are sampled only at send acceptance. Changes to address_line/data_line mid-frame do not affect tx.
- Send while busy (including on the done edge itself): the strobe is ignored, the current frame is unaffected, and overrun is set to 1. overrun holds until reset.
- Send in IDLE on the cycle after done: accepted normally, giving back-to-back frames with tx never glitching low between them.
- Send held high for several cycles: the first cycle is accepted; the remaining cycles set overrun.
- Baud counter: counts 0..CLK_DIV-1 and wraps. It is cleared on every state entry so that bit edges align to state transitions.
- Reset mid-frame: tx returns to 1 at once, busy=0, and no done pulse is generated. The next send after reset deassertion starts a clean frame.
- Checksum arithmetic: 8-bit with carry discarded. Example: 01+FF+80 = 0x80.

Test Plan:
1. Basic frame, CLK_DIV=4: address=9'h1FF, data=8'h80, send pulse -> tx carries A5 01 FF 80 80. Each bit lasts 4 cycles. busy is high for 200 cycles, then done pulses once.
2. Zero frame: address=0, data=0 -> bytes A5 00 00 00 00. Verify start/stop bits at cycles 0 and 36 of each 40-cycle byte slot.
3. Input isolation and overrun: address=9'h001, data=8'hF0, send; at cycle 50 change data to 8'hE0 and pulse send -> frame still A5 00 01 F0 F1, overrun=1 and stays 1 after done.
4. Back-to-back: send one cycle after done with address=9'h002, data=8'hC0 -> second frame A5 00 02 C0 C2 starts with no extra idle bit. overrun stays 0.
5. Reset mid-frame: assert reset at cycle 90 of a frame -> tx=1 and busy=0 within the same cycle, no done pulse. A subsequent send yields a complete, correct frame.
6. Width check, DATA_WIDTH=4, ADDRESS_WIDTH=16: address=16'hABCD, data=4'hF -> bytes A5 AB CD 0F 87.

Source files
------------

// File: rtl/rom_dump_uart_tx.sv
// Sends one ROM read result to the host PC as a 5-byte UART frame (8N1, LSB first).
// Byte order: A5 sync, address high, address low, data, then an 8-bit checksum of bytes 1..3.
module rom_dump_uart_tx #(
    parameter int DATA_WIDTH    = 8,
    parameter int ADDRESS_WIDTH = 9,
    parameter int CLK_DIV       = 434
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     send,
    input  logic [ADDRESS_WIDTH-1:0] address_line,
    input  logic [DATA_WIDTH-1:0]    data_line,
    output logic                     tx,
    output logic                     busy,
    output logic                     done,
    output logic                     overrun
);

    localparam int BAUD_W = $clog2(CLK_DIV);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLK_DIV - 1);
    localparam logic [7:0] SYNC_BYTE = 8'hA5;
    localparam logic [2:0] LAST_BYTE = 3'd4;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t            state_q, state_d;
    logic [BAUD_W-1:0] baud_q, baud_d;
    logic [2:0]        bit_idx_q, bit_idx_d;
    logic [2:0]        byte_idx_q, byte_idx_d;
    logic [7:0]        shift_q, shift_d;
    logic [15:0]       addr_q, addr_d;
    logic [7:0]        data_q, data_d;
    logic [7:0]        csum_q, csum_d;
    logic              done_q, done_d;
    logic              overrun_q, overrun_d;

    logic [15:0]       addr_ext;
    logic [7:0]        data_ext;
    logic              baud_last;

    function automatic logic [7:0] frame_byte(input logic [2:0]  idx,
                                              input logic [15:0] a,
                                              input logic [7:0]  d,
                                              input logic [7:0]  c);
        case (idx)
            3'd0:    frame_byte = SYNC_BYTE;
            3'd1:    frame_byte = a[15:8];
            3'd2:    frame_byte = a[7:0];
            3'd3:    frame_byte = d;
            default: frame_byte = c;
        endcase
    endfunction

    always_comb begin
        addr_ext  = 16'(address_line);
        data_ext  = 8'(data_line);
        baud_last = (baud_q == BAUD_LAST);
    end

    // The baud counter restarts on every state change so each bit edge lines up with a transition.
    always_comb begin
        state_d    = state_q;
        baud_d     = baud_q;
        bit_idx_d  = bit_idx_q;
        byte_idx_d = byte_idx_q;
        shift_d    = shift_q;
        addr_d     = addr_q;
        data_d     = data_q;
        csum_d     = csum_q;
        done_d     = 1'b0;
        overrun_d  = overrun_q | (send && (state_q != IDLE));

        case (state_q)
            IDLE: begin
                baud_d = '0;
                if (send) begin
                    addr_d     = addr_ext;
                    data_d     = data_ext;
                    csum_d     = addr_ext[15:8] + addr_ext[7:0] + data_ext;
                    byte_idx_d = 3'd0;
                    bit_idx_d  = 3'd0;
                    shift_d    = SYNC_BYTE;
                    state_d    = START;
                end
            end
            START: begin
                if (baud_last) begin
                    baud_d    = '0;
                    bit_idx_d = 3'd0;
                    state_d   = DATA;
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
            DATA: begin
                if (baud_last) begin
                    baud_d  = '0;
                    shift_d = {1'b0, shift_q[7:1]};
                    if (bit_idx_q == 3'd7) begin
                        state_d = STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
            STOP: begin
                if (baud_last) begin
                    baud_d = '0;
                    if (byte_idx_q < LAST_BYTE) begin
                        byte_idx_d = byte_idx_q + 3'd1;
                        shift_d    = frame_byte(byte_idx_q + 3'd1, addr_q, data_q, csum_q);
                        state_d    = START;
                    end else begin
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                baud_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            baud_q     <= '0;
            bit_idx_q  <= '0;
            byte_idx_q <= '0;
            shift_q    <= '0;
            addr_q     <= '0;
            data_q     <= '0;
            csum_q     <= '0;
            done_q     <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            baud_q     <= baud_d;
            bit_idx_q  <= bit_idx_d;
            byte_idx_q <= byte_idx_d;
            shift_q    <= shift_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            csum_q     <= csum_d;
            done_q     <= done_d;
            overrun_q  <= overrun_d;
        end
    end

    // Line level comes straight from state flops, so reset forces it high immediately.
    always_comb begin
        case (state_q)
            START:   tx = 1'b0;
            DATA:    tx = shift_q[0];
            default: tx = 1'b1;
        endcase
    end

    assign busy    = (state_q != IDLE);
    assign done    = done_q;
    assign overrun = overrun_q;

endmodule

// File: tb/tb_rom_dump_uart_tx.sv
// Self-checking bench for rom_dump_uart_tx: a 9-bit/8-bit instance and a 16-bit/4-bit instance, both at CLK_DIV=4.
module tb_rom_dump_uart_tx;

    localparam int DIV       = 4;
    localparam int FRAME_CYC = 50 * DIV;

    logic        clk = 1'b0;
    logic        reset;

    logic        send_a;
    logic [8:0]  addr_a;
    logic [7:0]  data_a;
    logic        tx_a, busy_a, done_a, overrun_a;

    logic        send_b;
    logic [15:0] addr_b;
    logic [3:0]  data_b;
    logic        tx_b, busy_b, done_b, overrun_b;

    int vecCount = 0;
    int errCount = 0;

    always #5 clk = ~clk;

    rom_dump_uart_tx #(.DATA_WIDTH(8), .ADDRESS_WIDTH(9), .CLK_DIV(DIV)) dut_a (
        .clk(clk), .reset(reset), .send(send_a), .address_line(addr_a), .data_line(data_a),
        .tx(tx_a), .busy(busy_a), .done(done_a), .overrun(overrun_a)
    );

    rom_dump_uart_tx #(.DATA_WIDTH(4), .ADDRESS_WIDTH(16), .CLK_DIV(DIV)) dut_b (
        .clk(clk), .reset(reset), .send(send_b), .address_line(addr_b), .data_line(data_b),
        .tx(tx_b), .busy(busy_b), .done(done_b), .overrun(overrun_b)
    );

    typedef struct {
        bit          which;
        logic [15:0] addr;
        logic [7:0]  data;
        logic [39:0] expBytes;
    } vec_t;

    vec_t vecs[6];

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vecCount++;
        if (actual !== expected) begin
            errCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    // Called at a negedge; the strobe is taken at the following posedge and we return at the next negedge (frame cycle 0).
    task automatic applyStimulus(input bit which, input logic [15:0] addr, input logic [7:0] data);
        if (which) begin
            addr_b = addr;
            data_b = data[3:0];
            send_b = 1'b1;
        end else begin
            addr_a = addr[8:0];
            data_a = data;
            send_a = 1'b1;
        end
        @(negedge clk);
        send_a = 1'b0;
        send_b = 1'b0;
    endtask

    task automatic pulseReset();
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    // Compares tx every cycle against the ideal 8N1 waveform; optional mid-frame send/data change on instance a.
    task automatic checkFrame(input bit which, input logic [39:0] expBytes, input int injectAt, input string tag);
        int txErr[5];
        int ctlErr;
        logic [7:0] decoded[5];
        logic expTx, txNow, busyNow, doneNow;
        int j, p;
        ctlErr = 0;
        for (int b = 0; b < 5; b++) begin
            txErr[b]   = 0;
            decoded[b] = 8'h00;
        end
        for (int k = 0; k < FRAME_CYC; k++) begin
            j = k / 40;
            p = (k % 40) / DIV;
            if (p == 0)      expTx = 1'b0;
            else if (p == 9) expTx = 1'b1;
            else             expTx = expBytes[39 - 8*j - 8 + p];
            txNow   = which ? tx_b   : tx_a;
            busyNow = which ? busy_b : busy_a;
            doneNow = which ? done_b : done_a;
            if (txNow !== expTx) txErr[j]++;
            if (busyNow !== 1'b1 || doneNow !== 1'b0) ctlErr++;
            if (p >= 1 && p <= 8 && (k % DIV) == 2) decoded[j][p-1] = txNow;
            if (k == injectAt) begin
                data_a = 8'hE0;
                addr_a = 9'h0FF;
                send_a = 1'b1;
            end else if (k == injectAt + 1) begin
                send_a = 1'b0;
            end
            @(negedge clk);
        end
        send_a = 1'b0;
        for (int b = 0; b < 5; b++) begin
            checkOutput($sformatf("%s byte%0d value", tag, b), decoded[b], expBytes[39 - 8*b -: 8]);
            checkOutput($sformatf("%s byte%0d bad tx cycles", tag, b), txErr[b], 0);
        end
        checkOutput($sformatf("%s busy/done bad cycles", tag), ctlErr, 0);
        checkOutput($sformatf("%s done at end", tag), which ? done_b : done_a, 1);
        checkOutput($sformatf("%s busy at end", tag), which ? busy_b : busy_a, 0);
        checkOutput($sformatf("%s tx at end", tag), which ? tx_b : tx_a, 1);
    endtask

    initial begin
        int seen;

        vecs[0] = '{1'b0, 16'h01FF, 8'h80, 40'hA5_01_FF_80_80};
        vecs[1] = '{1'b0, 16'h0000, 8'h00, 40'hA5_00_00_00_00};
        vecs[2] = '{1'b0, 16'h00AA, 8'h55, 40'hA5_00_AA_55_FF};
        vecs[3] = '{1'b0, 16'h0155, 8'h01, 40'hA5_01_55_01_57};
        vecs[4] = '{1'b1, 16'hABCD, 8'h0F, 40'hA5_AB_CD_0F_87};
        vecs[5] = '{1'b1, 16'h00FF, 8'h01, 40'hA5_00_FF_01_00};

        reset  = 1'b1;
        send_a = 1'b0; addr_a = '0; data_a = '0;
        send_b = 1'b0; addr_b = '0; data_b = '0;
        repeat (3) @(negedge clk);
        checkOutput("reset tx", tx_a, 1);
        checkOutput("reset busy", busy_a, 0);
        checkOutput("reset done", done_a, 0);
        checkOutput("reset overrun", overrun_a, 0);
        checkOutput("reset tx b", tx_b, 1);
        reset = 1'b0;
        @(negedge clk);

        for (int v = 0; v < 6; v++) begin
            applyStimulus(vecs[v].which, vecs[v].addr, vecs[v].data);
            checkFrame(vecs[v].which, vecs[v].expBytes, -1, $sformatf("vec%0d", v));
            @(negedge clk);
            checkOutput($sformatf("vec%0d done one cycle", v), vecs[v].which ? done_b : done_a, 0);
            checkOutput($sformatf("vec%0d idle busy", v), vecs[v].which ? busy_b : busy_a, 0);
            checkOutput($sformatf("vec%0d overrun", v), vecs[v].which ? overrun_b : overrun_a, 0);
            repeat (3) @(negedge clk);
        end

        $display("[TB] input isolation and overrun");
        applyStimulus(1'b0, 16'h0001, 8'hF0);
        checkFrame(1'b0, 40'hA5_00_01_F0_F1, 50, "isolate");
        checkOutput("isolate overrun at done", overrun_a, 1);
        repeat (5) @(negedge clk);
        checkOutput("isolate overrun sticky", overrun_a, 1);
        checkOutput("isolate no restart", busy_a, 0);

        $display("[TB] send on the done edge");
        pulseReset();
        checkOutput("reset clears overrun", overrun_a, 0);
        applyStimulus(1'b0, 16'h00AA, 8'h55);
        checkFrame(1'b0, 40'hA5_00_AA_55_FF, FRAME_CYC - 1, "doneedge");
        @(negedge clk);
        checkOutput("doneedge overrun", overrun_a, 1);
        checkOutput("doneedge ignored busy", busy_a, 0);
        checkOutput("doneedge ignored tx", tx_a, 1);

        $display("[TB] back-to-back frames");
        pulseReset();
        applyStimulus(1'b0, 16'h01FF, 8'h80);
        checkFrame(1'b0, 40'hA5_01_FF_80_80, -1, "b2b first");
        applyStimulus(1'b0, 16'h0002, 8'hC0);
        checkFrame(1'b0, 40'hA5_00_02_C0_C2, -1, "b2b second");
        checkOutput("b2b overrun", overrun_a, 0);
        @(negedge clk);

        $display("[TB] reset mid-frame");
        applyStimulus(1'b0, 16'h0155, 8'h01);
        repeat (90) @(negedge clk);
        reset = 1'b1;
        #1;
        checkOutput("midreset tx", tx_a, 1);
        checkOutput("midreset busy", busy_a, 0);
        @(negedge clk);
        reset = 1'b0;
        seen = 0;
        repeat (FRAME_CYC) begin
            @(negedge clk);
            if (done_a !== 1'b0 || busy_a !== 1'b0) seen++;
        end
        checkOutput("midreset no done/busy", seen, 0);
        applyStimulus(1'b0, 16'h01FF, 8'h80);
        checkFrame(1'b0, 40'hA5_01_FF_80_80, -1, "after reset");

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, errCount);
        $finish;
    end

endmodule
